// File: rtl/physics_pkg.sv
// Shared physics types: oriented bounding boxes, contacts,
// and the scheduler state encoding.
package physics_pkg;

  typedef struct packed {
    logic signed [21:0] pos_x;
    logic signed [21:0] pos_y;
    logic signed [15:0] u_x;
    logic signed [15:0] u_y;
    logic signed [15:0] v_x;
    logic signed [15:0] v_y;
    logic        [23:0] half_w;
    logic        [23:0] half_h;
  } obb_t;

  typedef struct packed {
    logic signed [15:0] nrm_x;
    logic signed [15:0] nrm_y;
    logic signed [21:0] loc_x;
    logic signed [21:0] loc_y;
    logic        [23:0] pen;
  } contact_t;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int unsigned pair_count(
    input int unsigned n
  );
    return (n * (n - 1)) / 2;
  endfunction

endpackage

// File: rtl/pair_iterator.sv
// Walks unordered pairs (i<j) in lexicographic order,
// wrapping back to (0,1) after the last pair.
module pair_iterator #(
  parameter int N_BODIES = 8,
  parameter int IDX_W    = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             advance,
  input  logic             clear,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  localparam logic [IDX_W-1:0] LastJ = IDX_W'(N_BODIES - 1);
  localparam logic [IDX_W-1:0] LastI = IDX_W'(N_BODIES - 2);

  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;

  assign last = (i_q == LastI) && (j_q == LastJ);
  assign i    = i_q;
  assign j    = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear || (advance && last)) begin
      i_d = '0;
      j_d = IDX_W'(1);
    end else if (advance) begin
      if (j_q == LastJ) begin
        i_d = i_q + IDX_W'(1);
        j_d = i_q + IDX_W'(2);
      end else begin
        j_d = j_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      i_q <= '0;
      j_q <= IDX_W'(1);
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Sweeps all body pairs through an external detector and
// streams colliding contacts to the resolver.
module collision_scheduler
  import physics_pkg::*;
#(
  parameter int N_BODIES = 8,
  parameter int IDX_W    = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [N_BODIES-1:0] body_active,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    rd_addr_a,
  output logic [IDX_W-1:0]    rd_addr_b,
  input  obb_t                rd_obb_a,
  input  obb_t                rd_obb_b,
  output obb_t                det_obb1,
  output obb_t                det_obb2,
  input  logic                det_is_collision,
  input  contact_t            det_contact,
  output logic                contact_valid,
  input  logic                contact_ready,
  output contact_t            contact,
  output logic [IDX_W-1:0]    contact_idx_a,
  output logic [IDX_W-1:0]    contact_idx_b,
  output logic [7:0]          contact_count
);

  state_t              state_q, state_d;
  logic [N_BODIES-1:0] active_q;
  obb_t                obb1_q, obb2_q;
  contact_t            contact_q;
  logic [IDX_W-1:0]    idx_a_q, idx_b_q;
  logic [7:0]          count_q, count_d;

  logic             adv, clr, last;
  logic [IDX_W-1:0] pi, pj;

  pair_iterator #(
    .N_BODIES(N_BODIES),
    .IDX_W   (IDX_W)
  ) u_iter (
    .Clk    (Clk),
    .Reset  (Reset),
    .advance(adv),
    .clear  (clr),
    .i      (pi),
    .j      (pj),
    .last   (last)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    adv     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          count_d = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (active_q[pi] && active_q[pj]) begin
          state_d = ST_LATCH;
        end else begin
          adv     = 1'b1;
          state_d = last ? ST_DONE : ST_FETCH;
        end
      end
      ST_LATCH: state_d = ST_EVAL;
      ST_EVAL: begin
        if (det_is_collision) begin
          state_d = ST_EMIT;
        end else begin
          adv     = 1'b1;
          state_d = last ? ST_DONE : ST_FETCH;
        end
      end
      ST_EMIT: begin
        if (contact_ready) begin
          adv     = 1'b1;
          state_d = last ? ST_DONE : ST_FETCH;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      obb1_q    <= '0;
      obb2_q    <= '0;
      contact_q <= '0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (state_q == ST_IDLE && start) active_q <= body_active;
      if (state_q == ST_LATCH) begin
        obb1_q <= rd_obb_a;
        obb2_q <= rd_obb_b;
      end
      // Holding regs keep the contact stable through backpressure
      if (state_q == ST_EVAL) begin
        contact_q <= det_contact;
        idx_a_q   <= pi;
        idx_b_q   <= pj;
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign contact_valid = (state_q == ST_EMIT);
  assign rd_addr_a     = pi;
  assign rd_addr_b     = pj;
  assign det_obb1      = obb1_q;
  assign det_obb2      = obb2_q;
  assign contact       = contact_q;
  assign contact_idx_a = idx_a_q;
  assign contact_idx_b = idx_b_q;
  assign contact_count = count_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Frame-level checks of collision_scheduler against a
// behavioural body store and detector.
module tb_collision_scheduler;
  import physics_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] body_active = '0;
  logic       busy, done;
  logic [2:0] rd_addr_a, rd_addr_b;
  obb_t       rd_obb_a, rd_obb_b;
  obb_t       det_obb1, det_obb2;
  logic       det_is_collision;
  contact_t   det_contact;
  logic       contact_valid;
  logic       contact_ready = 1'b1;
  contact_t   contact;
  logic [2:0] contact_idx_a, contact_idx_b;
  logic [7:0] contact_count;
  logic [7:0] ovl = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  collision_scheduler #(
    .N_BODIES(8),
    .IDX_W   (3)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .start           (start),
    .body_active     (body_active),
    .busy            (busy),
    .done            (done),
    .rd_addr_a       (rd_addr_a),
    .rd_addr_b       (rd_addr_b),
    .rd_obb_a        (rd_obb_a),
    .rd_obb_b        (rd_obb_b),
    .det_obb1        (det_obb1),
    .det_obb2        (det_obb2),
    .det_is_collision(det_is_collision),
    .det_contact     (det_contact),
    .contact_valid   (contact_valid),
    .contact_ready   (contact_ready),
    .contact         (contact),
    .contact_idx_a   (contact_idx_a),
    .contact_idx_b   (contact_idx_b),
    .contact_count   (contact_count)
  );

  function automatic obb_t body(input int k);
    obb_t o;
    o.pos_x  = 22'(k * 40961 + 17);
    o.pos_y  = 22'(k * 1237 + 5);
    o.u_x    = 16'((k * 256) + k);
    o.u_y    = 16'(k * 313 + 7);
    o.v_x    = 16'(k * 911 + 1);
    o.v_y    = 16'(k * 59 + 3);
    o.half_w = 24'(k * 70001 + 9);
    o.half_h = 24'(k * 5003 + 2);
    return o;
  endfunction

  function automatic contact_t det_fn(
    input obb_t a,
    input obb_t b
  );
    contact_t c;
    c.nrm_x = a.u_y ^ b.v_x;
    c.nrm_y = a.v_y - b.u_y;
    c.loc_x = a.pos_x + b.pos_y;
    c.loc_y = a.pos_y ^ b.pos_x;
    c.pen   = a.half_w + b.half_h;
    return c;
  endfunction

  // One-cycle read latency body store
  always @(posedge Clk) begin
    rd_obb_a <= body(int'(rd_addr_a));
    rd_obb_b <= body(int'(rd_addr_b));
  end

  always_comb begin
    det_is_collision = ovl[det_obb1.u_x[2:0]]
                     & ovl[det_obb2.u_x[2:0]];
    det_contact = det_fn(det_obb1, det_obb2);
  end

  task automatic check(
    input string        name,
    input logic [159:0] act,
    input logic [159:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] ovl;
    int         stall;
    int         pulse_cyc;
    logic       pulse_done;
    int         exp_done;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [8];

  task automatic run_frame(input int id, input vec_t v);
    int cyc = 0;
    int k = 0;
    int stall_left = v.stall;
    int done_cyc = -1;
    int ea[$];
    int eb[$];
    string p = $sformatf("v%0d", id);
    for (int a = 0; a < 8; a++)
      for (int b = a + 1; b < 8; b++)
        if (v.mask[a] && v.mask[b] && v.ovl[a] && v.ovl[b]) begin
          ea.push_back(a);
          eb.push_back(b);
        end
    ovl = v.ovl;
    body_active = v.mask;
    contact_ready = 1'b1;
    start = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(posedge Clk);
      #1;
      cyc++;
      start = (cyc == v.pulse_cyc);
      body_active = ~v.mask;
      if (cyc == 1)
        check({p, ".fetch01"},
              {busy, rd_addr_a, rd_addr_b, contact_count},
              {1'b1, 3'd0, 3'd1, 8'd0});
      if (contact_valid) begin
        if (k >= ea.size()) begin
          check({p, ".extra"}, contact_valid, 1'b0);
          contact_ready = 1'b1;
        end else begin
          check({p, ".idx"}, {contact_idx_a, contact_idx_b},
                {3'(ea[k]), 3'(eb[k])});
          check({p, ".data"}, contact,
                det_fn(body(ea[k]), body(eb[k])));
          if (stall_left > 0) begin
            contact_ready = 1'b0;
            stall_left--;
          end else begin
            contact_ready = 1'b1;
            k++;
          end
        end
      end else begin
        contact_ready = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        if (v.pulse_done) start = 1'b1;
      end
    end
    check({p, ".done_cyc"}, done_cyc, v.exp_done);
    check({p, ".count"}, contact_count, v.exp_cnt[7:0]);
    check({p, ".emitted"}, k, ea.size());
    @(posedge Clk);
    #1;
    start = 1'b0;
    check({p, ".idle"}, {done, busy, contact_valid}, 3'b000);
  endtask

  task automatic reset_in_emit();
    int k = 0;
    int held = 0;
    int cyc = 0;
    ovl = 8'hFF;
    body_active = 8'hFF;
    contact_ready = 1'b1;
    start = 1'b1;
    while (held < 2 && cyc < 200) begin
      @(posedge Clk);
      #1;
      cyc++;
      start = 1'b0;
      if (contact_valid) begin
        if (k < 3) begin
          contact_ready = 1'b1;
          k++;
        end else begin
          contact_ready = 1'b0;
          held++;
        end
      end
    end
    check("rst.reach_emit", held, 2);
    check("rst.pre_count", contact_count, 8'd3);
    check("rst.pre_valid", contact_valid, 1'b1);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    contact_ready = 1'b1;
    check("rst.ctrl",
          {busy, done, contact_valid, contact_count},
          {1'b0, 1'b0, 1'b0, 8'd0});
    check("rst.pair", {rd_addr_a, rd_addr_b}, {3'd0, 3'd1});
    check("rst.contact",
          {contact, contact_idx_a, contact_idx_b}, '0);
    check("rst.obb", {det_obb1, det_obb2}, '0);
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h00, 0, 3, 1'b0, 85, 0};
    vecs[1] = '{8'h24, 8'h24, 0, 18, 1'b1, 32, 1};
    vecs[2] = '{8'hFF, 8'hFF, 0, 0, 1'b0, 113, 28};
    vecs[3] = '{8'hFF, 8'hFF, 10, 0, 1'b0, 123, 28};
    vecs[4] = '{8'h81, 8'h81, 0, 0, 1'b0, 32, 1};
    vecs[5] = '{8'hC0, 8'hC0, 0, 0, 1'b0, 32, 1};
    vecs[6] = '{8'h00, 8'hFF, 0, 0, 1'b0, 29, 0};
    vecs[7] = '{8'h07, 8'h05, 0, 0, 1'b0, 36, 1};

    repeat (3) @(posedge Clk);
    #1;
    check("reset.ctrl",
          {busy, done, contact_valid, contact_count},
          {1'b0, 1'b0, 1'b0, 8'd0});
    check("reset.pair", {rd_addr_a, rd_addr_b}, {3'd0, 3'd1});
    check("reset.contact",
          {contact, contact_idx_a, contact_idx_b}, '0);
    check("reset.obb", det_obb1, '0);
    Reset = 1'b0;

    for (int n = 0; n < 8; n++) run_frame(n, vecs[n]);

    reset_in_emit();
    run_frame(8, vecs[2]);

    start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences the shared combinational `collision_detector` over every unordered pair of up to `N_BODIES` rigid bodies. It fetches OBB pairs from the body store, registers them into the detector, and streams each colliding pair's contact out over a valid/ready interface to the physics resolver. It sits between the body-state RAM and the contact resolver, and runs once per physics frame on `start`.

## Interface
Parameters:
- `N_BODIES`, 8: number of body slots. Must be at least 2.
- `IDX_W`, 3: body index width, equal to clog2(`N_BODIES`).

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `start` in 1: begin a frame sweep. Sampled only in IDLE.
- `body_active` in `N_BODIES`: slot enable mask, latched on start accept.
- `busy` out 1: high from start accept until DONE inclusive.
- `done` out 1: one-cycle pulse in DONE.
- `rd_addr_a`, `rd_addr_b` out `IDX_W`: body-store read addresses.
- `rd_obb_a`, `rd_obb_b` in `obb_t`: read data, valid the cycle after the address.
- `det_obb1`, `det_obb2` out `obb_t`: registered detector inputs.
- `det_is_collision` in 1; `det_contact` in `contact_t`: detector outputs, combinational from `det_obb*`.
- `contact_valid` out 1; `contact_ready` in 1: output handshake.
- `contact` out `contact_t`: normal, location, penetration.
- `contact_idx_a`, `contact_idx_b` out `IDX_W`: pair indices, with a < b.
- `contact_count` out 8: contacts emitted this frame, saturating at 255.

## Operation
- States: IDLE, FETCH, LATCH, EVAL, EMIT, DONE.
- Pair order is lexicographic: (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1). Pair indices `i`, `j` reset to (0,1).
- **IDLE**
  - `start`=1: latch `body_active`, clear `contact_count`, set i=0, j=1, go to FETCH.
  - `start` in any other state is ignored.
- **FETCH**
  - Drive `rd_addr_a`=i and `rd_addr_b`=j.
  - If `active[i]` and `active[j]` are both set: go to LATCH.
  - Otherwise: advance the pair. Go to DONE if this was the last pair, else stay in FETCH. A skipped pair costs 1 cycle.
- **LATCH**: register `rd_obb_a`→`det_obb1` and `rd_obb_b`→`det_obb2`. Go to EVAL.
- **EVAL**
  - Register `det_is_collision`, `det_contact`, i and j into the output holding registers.
  - If collision: go to EMIT.
  - Else: advance the pair and go to FETCH, or to DONE if this was the last pair.
- **EMIT**
  - `contact_valid`=1. `contact`, `contact_idx_a`, `contact_idx_b` are held stable until `contact_ready`.
  - On the transfer cycle (valid & ready): increment `contact_count` (saturating) and advance the pair. Go to FETCH, or to DONE if this was the last pair.
- **DONE**: `done`=1 for one cycle, then go to IDLE. `busy` drops in IDLE.
- Pair advance: if j == N-1 then i←i+1, j←i+2; else j←j+1. The last pair is i=N-2, j=N-1.
- Arithmetic: index compares only. The detector owns all fixed-point math. Contact fields pass through bit-exact, with no re-quantisation.
- Reset from any state:
  - State IDLE; `busy`, `done`, `contact_valid` = 0.
  - i=0, j=1; `contact_count`=0.
  - `det_obb*`, `contact`, `contact_idx_*` = 0.
  - An in-flight contact is dropped, never emitted.
- Changing `body_active` mid-sweep has no effect.

## Timing
- Start accepted in cycle 0; first FETCH in cycle 1.
- Per-pair cost:
  - Skipped pair: 1 cycle.
  - Evaluated, no collision: 3 cycles.
  - Colliding: 3 cycles, plus the EMIT cycles (at least 1; exactly 1 with `ready` held high).
- DONE occurs the cycle after the last pair completes.
- Read latency is exactly 1 cycle. The detector input-to-output path must fit in a single cycle, from LATCH register to EVAL capture.
- `contact_valid` never depends combinationally on `contact_ready`.

## Structure
- Shared package `physics_pkg`:
  - `obb_t`: pos Q8.14 ×2, u/v Q2.14 ×2, halfWidth/halfHeight Q8.16.
  - `contact_t`: normal Q2.14 ×2, location Q8.14 ×2, penetration Q8.16 (24 bits).
  - State enum and pair-count helper.
- Sub-module `pair_iterator`: holds i and j, with `advance` and `clear` inputs and a `last` output.
- The detector is instanced outside this block and connected via the `det_*` ports, so it can be time-shared with debug tooling.

## Test plan
- **All active, no overlaps, N=8.** Start in cycle 0 → FETCH (0,1) in cycle 1, `done` in cycle 85, no `contact_valid`, `contact_count`=0.
- **Mask 0b00100100, bodies 2 and 5 overlap, ready=1.**
  - One contact with idx_a=2, idx_b=5, fields equal to the detector output.
  - 27 skipped pairs; `done` in cycle 32; `contact_count`=1.
- **All 8 active and mutually overlapping, ready=1.**
  - 28 contacts in lexicographic order, (0,1) first and (6,7) last.
  - `done` in cycle 113; `contact_count`=28.
- **Backpressure.** Same as the previous case, but `contact_ready` is held low for 10 cycles on the first contact → contact held stable for 10 cycles, `done` in cycle 123.
- **Reset during EMIT with ready=0.**
  - Next cycle: IDLE, `busy`=0, `contact_valid`=0, `contact_count`=0.
  - A fresh start reruns from pair (0,1).
- **Start pulsed during EVAL and during DONE** → ignored. A start in the IDLE cycle after DONE is accepted and `contact_count` clears.
